// File: rtl/huffman_encoder.sv
// Static Huffman coder for a short parallel byte string: counts symbols,
// builds the tree one merge per cycle, then emits right-aligned codewords.
module huffman_encoder #(
  parameter int MAX_STRING_LENGTH = 10,
  parameter int MAX_CHAR_COUNT    = 5
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [0:MAX_STRING_LENGTH-1][7:0]             data_in,
  input  logic                                          data_en,
  output logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] encoded_value,
  output logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] encoded_mask,
  output logic [MAX_CHAR_COUNT-1:0][7:0]                character,
  output logic                                          done
);

  localparam int MSL   = MAX_STRING_LENGTH;
  localparam int MCC   = MAX_CHAR_COUNT;
  localparam int NODES = 2 * MCC - 1;
  localparam int NW    = $clog2(NODES + 1);
  localparam int WW    = $clog2(MSL + 1);
  localparam int SW    = (MSL > 1) ? $clog2(MSL) : 1;
  localparam int UW    = $clog2(MCC + 1);
  localparam int LW    = $clog2(MCC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COUNT, S_BUILD, S_ENCODE, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [0:MSL-1][7:0]       data_q, data_d;
  logic [SW-1:0]             slot_q, slot_d;
  logic [UW-1:0]             uniq_q, uniq_d;
  logic [NW-1:0]             node_cnt_q, node_cnt_d;
  logic [MCC-1:0][7:0]       char_q, char_d;
  logic [WW-1:0]             weight_q [NODES];
  logic [WW-1:0]             weight_d [NODES];
  logic [NW-1:0]             parent_q [NODES];
  logic [NW-1:0]             parent_d [NODES];
  logic [NODES-1:0]          side_q, side_d;
  logic [NODES-1:0]          active_q, active_d;
  logic [MCC-1:0][MCC-1:0]   value_q, value_d;
  logic [MCC-1:0][MCC-1:0]   mask_q, mask_d;
  logic [MCC-1:0][7:0]       char_out_q, char_out_d;
  logic                      done_q, done_d;

  logic [7:0]                cur_byte;
  logic                      hit;
  logic [UW-1:0]             hit_idx;
  logic [NW-1:0]             pick_a, pick_b;
  logic [WW-1:0]             w_a, w_b;
  logic                      found_a, found_b;
  logic [NW-1:0]             root_idx;
  logic [MCC-1:0][MCC-1:0]   enc_value, enc_mask;

  // Root of a U-leaf tree is always the last internal node, index 2U-2.
  assign root_idx = NW'(uniq_q) + NW'(uniq_q) - NW'(2);

  always_comb begin
    cur_byte = data_q[slot_q];
    hit      = 1'b0;
    hit_idx  = '0;
    for (int i = 0; i < MCC; i++) begin
      if (UW'(i) < uniq_q && char_q[i] == cur_byte) begin
        hit     = 1'b1;
        hit_idx = UW'(i);
      end
    end
  end

  // Strict '<' scanning upward keeps ties on the lower node index.
  always_comb begin
    found_a = 1'b0;
    pick_a  = '0;
    w_a     = '0;
    for (int i = 0; i < NODES; i++) begin
      if (active_q[i] && (!found_a || weight_q[i] < w_a)) begin
        found_a = 1'b1;
        pick_a  = NW'(i);
        w_a     = weight_q[i];
      end
    end
    found_b = 1'b0;
    pick_b  = '0;
    w_b     = '0;
    for (int i = 0; i < NODES; i++) begin
      if (active_q[i] && NW'(i) != pick_a && (!found_b || weight_q[i] < w_b)) begin
        found_b = 1'b1;
        pick_b  = NW'(i);
        w_b     = weight_q[i];
      end
    end
  end

  // Walking leaf-to-root yields the codeword LSB first, so it lands right-aligned.
  always_comb begin
    logic [NW-1:0] node;
    logic [LW-1:0] len;
    enc_value = '0;
    enc_mask  = '0;
    for (int l = 0; l < MCC; l++) begin
      node = NW'(l);
      len  = '0;
      for (int s = 0; s < MCC; s++) begin
        if (node != root_idx) begin
          enc_value[l][len] = side_q[node];
          enc_mask[l][len]  = 1'b1;
          len               = len + LW'(1);
          node              = parent_q[node];
        end
      end
      if (UW'(l) >= uniq_q) begin
        enc_value[l] = '0;
        enc_mask[l]  = '0;
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block infers a latch.
    state_d    = state_q;
    data_d     = data_q;
    slot_d     = slot_q;
    uniq_d     = uniq_q;
    node_cnt_d = node_cnt_q;
    char_d     = char_q;
    weight_d   = weight_q;
    parent_d   = parent_q;
    side_d     = side_q;
    active_d   = active_q;
    value_d    = value_q;
    mask_d     = mask_q;
    char_out_d = char_out_q;
    done_d     = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (data_en) begin
          data_d  = data_in;
          slot_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD, S_COUNT: begin
        if (cur_byte != 8'h00) begin
          if (hit) begin
            weight_d[NW'(hit_idx)] = weight_q[NW'(hit_idx)] + WW'(1);
          end else if (uniq_q < UW'(MCC)) begin
            char_d[uniq_q]         = cur_byte;
            weight_d[NW'(uniq_q)]  = WW'(1);
            active_d[NW'(uniq_q)]  = 1'b1;
            uniq_d                 = uniq_q + UW'(1);
          end
        end
        slot_d  = slot_q + SW'(1);
        state_d = S_COUNT;
        if (slot_q == SW'(MSL - 1)) begin
          node_cnt_d = NW'(uniq_d);
          if (uniq_d == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (uniq_d == UW'(1)) begin
            state_d = S_ENCODE;
          end else begin
            state_d = S_BUILD;
          end
        end
      end
      S_BUILD: begin
        weight_d[node_cnt_q] = w_a + w_b;
        parent_d[pick_a]     = node_cnt_q;
        parent_d[pick_b]     = node_cnt_q;
        side_d[pick_a]       = 1'b0;
        side_d[pick_b]       = 1'b1;
        active_d[pick_a]     = 1'b0;
        active_d[pick_b]     = 1'b0;
        active_d[node_cnt_q] = 1'b1;
        node_cnt_d           = node_cnt_q + NW'(1);
        if (node_cnt_q == root_idx) state_d = S_ENCODE;
      end
      S_ENCODE: begin
        value_d    = enc_value;
        mask_d     = enc_mask;
        char_out_d = char_q;
        done_d     = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      slot_q     <= '0;
      uniq_q     <= '0;
      node_cnt_q <= '0;
      char_q     <= '0;
      side_q     <= '0;
      active_q   <= '0;
      value_q    <= '0;
      mask_q     <= '0;
      char_out_q <= '0;
      done_q     <= 1'b0;
      // NOTE: the node tables are tiny and must read as a clean tree after reset,
      // so they are flops with reset rather than RAM.
      for (int i = 0; i < NODES; i++) begin
        weight_q[i] <= '0;
        parent_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge _d values.
      state_q    <= state_d;
      data_q     <= data_d;
      slot_q     <= slot_d;
      uniq_q     <= uniq_d;
      node_cnt_q <= node_cnt_d;
      char_q     <= char_d;
      side_q     <= side_d;
      active_q   <= active_d;
      value_q    <= value_d;
      mask_q     <= mask_d;
      char_out_q <= char_out_d;
      done_q     <= done_d;
      for (int i = 0; i < NODES; i++) begin
        weight_q[i] <= weight_d[i];
        parent_q[i] <= parent_d[i];
      end
    end
  end

  assign encoded_value = value_q;
  assign encoded_mask  = mask_q;
  assign character     = char_out_q;
  assign done          = done_q;

endmodule

// File: tb/tb_huffman_encoder.sv
// Randomised scoreboard bench for huffman_encoder against a leaf-set Huffman
// reference model.
module tb_huffman_encoder;

  localparam int MSL = 10;
  localparam int MCC = 5;
  localparam int LAT = MSL + 2 * MCC + 4;

  typedef logic [0:MSL-1][7:0] str_t;
  typedef struct {
    logic [MCC-1:0][7:0]     ch;
    logic [MCC-1:0][MCC-1:0] val;
    logic [MCC-1:0][MCC-1:0] msk;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    data_en = 1'b0;
  str_t                    data_in = '0;
  logic [MCC-1:0][MCC-1:0] encoded_value;
  logic [MCC-1:0][MCC-1:0] encoded_mask;
  logic [MCC-1:0][7:0]     character;
  logic                    done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  bit   done_seen = 1'b0;

  huffman_encoder #(.MAX_STRING_LENGTH(MSL), .MAX_CHAR_COUNT(MCC)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_en      (data_en),
    .encoded_value(encoded_value),
    .encoded_mask (encoded_mask),
    .character    (character),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic str_t make_str(input string s);
    str_t d = '0;
    int   n = s.len();
    for (int i = 0; i < n && i < MSL; i++) d[MSL - n + i] = s[i];
    return d;
  endfunction

  // Each tree node carries the set of leaves below it; a merge prepends its
  // bit to every member leaf's code above the bits already collected.
  function automatic exp_t model(input str_t d);
    byte unsigned chars[MCC];
    int   freq[MCC];
    int   w[2*MCC-1];
    bit   act[2*MCC-1];
    int   leaves[2*MCC-1];
    int   code[MCC];
    int   len[MCC];
    int   u = 0;
    int   n, a, b, found;
    exp_t e;
    for (int i = 0; i < MCC; i++) begin
      chars[i] = 0; freq[i] = 0; code[i] = 0; len[i] = 0;
    end
    for (int i = 0; i < 2*MCC-1; i++) begin
      w[i] = 0; act[i] = 0; leaves[i] = 0;
    end
    for (int s = 0; s < MSL; s++) begin
      if (d[s] != 8'h00) begin
        found = -1;
        for (int j = 0; j < u; j++) if (chars[j] == d[s]) found = j;
        if (found >= 0) freq[found]++;
        else if (u < MCC) begin
          chars[u] = d[s]; freq[u] = 1; u++;
        end
      end
    end
    for (int i = 0; i < u; i++) begin
      w[i] = freq[i]; act[i] = 1; leaves[i] = 1 << i;
    end
    n = u;
    for (int m = 0; m < u - 1; m++) begin
      a = -1;
      for (int i = 0; i < n; i++) if (act[i] && (a < 0 || w[i] < w[a])) a = i;
      b = -1;
      for (int i = 0; i < n; i++) if (act[i] && i != a && (b < 0 || w[i] < w[b])) b = i;
      for (int l = 0; l < u; l++) begin
        if (((leaves[a] >> l) & 1) != 0) len[l]++;
        if (((leaves[b] >> l) & 1) != 0) begin
          code[l] = code[l] | (1 << len[l]);
          len[l]++;
        end
      end
      w[n] = w[a] + w[b]; leaves[n] = leaves[a] | leaves[b]; act[n] = 1;
      act[a] = 0; act[b] = 0; n++;
    end
    e.ch = '0; e.val = '0; e.msk = '0;
    for (int l = 0; l < u; l++) begin
      e.ch[l]  = chars[l];
      e.val[l] = MCC'(code[l]);
      e.msk[l] = MCC'((1 << len[l]) - 1);
    end
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (done && !done_seen) begin
        done_seen = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          mon_e = sb_q.pop_front();
          check("character", 64'(character), 64'(mon_e.ch));
          check("encoded_value", 64'(encoded_value), 64'(mon_e.val));
          check("encoded_mask", 64'(encoded_mask), 64'(mon_e.msk));
        end
      end else if (!done) begin
        done_seen = 1'b0;
      end
    end
  end

  task automatic randomize_data();
    for (int i = 0; i < MSL; i++) data_in[i] = 8'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_done", 64'(done), 64'(0));
    check("reset_value", 64'(encoded_value), 64'(0));
    check("reset_mask", 64'(encoded_mask), 64'(0));
    check("reset_character", 64'(character), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input str_t d);
    exp_t e;
    int   k;
    e = model(d);
    @(negedge clk);
    data_in = d;
    data_en = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    data_en = 1'b0;
    randomize_data();
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!done && k < 3 * LAT);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", k);
      sb_q.delete();
    end else begin
      check("latency_cycles", 64'(k <= LAT ? 0 : k), 64'(0));
      repeat (3) begin
        @(negedge clk);
        data_en = 1'b1;
        randomize_data();
      end
      @(negedge clk);
      data_en = 1'b0;
      check("hold_done", 64'(done), 64'(1));
      check("hold_character", 64'(character), 64'(e.ch));
      check("hold_value", 64'(encoded_value), 64'(e.val));
      check("hold_mask", 64'(encoded_mask), 64'(e.msk));
    end
  endtask

  initial begin
    string directed[7];
    str_t  d;
    int    alpha;
    directed = '{"anuan", "aabb", "aaf", "aaaaa", "anushaanua", "", "abcdefgabc"};

    foreach (directed[i]) begin
      do_reset();
      run(make_str(directed[i]));
    end

    // Abort a run while merges are in progress, then confirm a clean rerun.
    do_reset();
    @(negedge clk);
    data_in = make_str("anushaanua");
    data_en = 1'b1;
    @(posedge clk);
    #1 data_en = 1'b0;
    repeat (11) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_done", 64'(done), 64'(0));
    check("abort_value", 64'(encoded_value), 64'(0));
    check("abort_mask", 64'(encoded_mask), 64'(0));
    check("abort_character", 64'(character), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run(make_str("aabb"));

    for (int r = 0; r < 40; r++) begin
      alpha = $urandom_range(1, 7);
      for (int i = 0; i < MSL; i++) begin
        if ($urandom_range(0, 3) == 0) d[i] = 8'h00;
        else d[i] = 8'(8'h61 + $urandom_range(0, alpha - 1));
      end
      do_reset();
      run(d);
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_encoder.md
Name: huffman_encoder

Overview:
- Computes a static Huffman code for a short byte string presented in parallel.
- Counts unique characters and their frequencies, builds the Huffman tree, and reports per-character codewords with validity masks.
- Standalone compute block: one string per run, results held until reset.

Parameters:
- MAX_STRING_LENGTH, 10, number of byte slots in data_in.
- MAX_CHAR_COUNT, 5, max unique characters tracked; also the max codeword length in bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- data_in  input  8*MAX_STRING_LENGTH  packed bytes [0:MAX_STRING_LENGTH-1][7:0]; slot 0 is the most-significant byte.
- data_en  input  1  start strobe/level; data_in is sampled on the first IDLE cycle it is high.
- encoded_value  output  MAX_CHAR_COUNT*MAX_CHAR_COUNT  [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]; entry i is the codeword of character[i], right-aligned.
- encoded_mask  output  MAX_CHAR_COUNT*MAX_CHAR_COUNT  same shape; entry i has its low len_i bits set.
- character  output  8*MAX_CHAR_COUNT  [MAX_CHAR_COUNT-1:0][7:0]; unique characters in first-appearance order.
- done  output  1  results valid.

Behaviour:
- Reset (async, active-high): state=IDLE; done=0; encoded_value, encoded_mask and character all 0; internal counters and tree cleared. Reset mid-run aborts immediately.
- States: IDLE -> LOAD -> COUNT -> BUILD -> ENCODE -> DONE.
- IDLE -> LOAD: data_en=1 latches data_in.
- LOAD/COUNT: scan slots 0..MAX_STRING_LENGTH-1, one per cycle.
  - Byte 0x00 is padding and is ignored; a right-justified short string such as "anuan" therefore works.
  - A new byte value gets the next leaf index 0,1,2… with freq=1; a repeated value increments its freq.
  - Unique characters beyond MAX_CHAR_COUNT are dropped and not counted.
- BUILD: U = unique count; leaves 0..U-1, weight = freq. Exactly U-1 merges, one per cycle.
  - Each merge picks the lowest-weight active node, then the next lowest.
  - Ties go to the lower node index.
  - First pick becomes the left child (bit 0); second pick becomes the right child (bit 1).
  - The new internal node gets index U, U+1…, with weight = sum of its children.
- ENCODE: codeword = root-to-leaf path, root bit at the MSB; len = depth (at most MAX_CHAR_COUNT). Store the codeword right-aligned in the low len bits and zero-fill the remainder.
- Special cases:
  - U=1: len=0, so value=0 and mask=0 (no encoding); done still asserts.
  - U=0 (all bytes 0x00): go directly to DONE with all outputs 0.
- Unused slots i>=U: character, value and mask are 0.
- DONE: done=1. Outputs and done hold until reset; data_en is ignored in DONE.
- Latency: done rises no later than MAX_STRING_LENGTH + 2*MAX_CHAR_COUNT + 4 cycles after the data_en sample.
- data_in changes after the sample have no effect.
- Outputs are registered; no combinational path from inputs.

Test Plan:
- data_in="anuan" (right-justified, 5 leading 0x00), data_en=1.
  - character[0..2] = 'a','n','u'.
  - a = 11 (mask 00011), n = 0 (mask 00001), u = 10 (mask 00011).
  - done=1 within the latency bound.
- "aabb": a = 0, b = 1, both masks 00001.
- "aaf": a = 1, f = 0, both masks 00001.
- "aaaaa": character[0]='a', mask 0, value 0, done=1.
- "anushaanua": 5 unique characters; sum of freq*len over all characters equals the optimal Huffman total; the codes are prefix-free.
- Reset asserted mid-BUILD: outputs and done go to 0 immediately. Rerunning "aabb" yields the same codes as above.
